// File: rtl/tlb_search_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlb_search_arbiter_if : requester (I/D) and TLB search-port bundle       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface tlb_search_arbiter_if #(
   parameter int TLBNUM = 16
);
   localparam int IDX_W = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;

   logic             i_req;
   logic [18:0]      i_vpn;
   logic             i_odd;
   logic [7:0]       i_asid;
   logic             i_gnt;
   logic             i_rvalid;
   logic             i_found;
   logic [IDX_W-1:0] i_index;
   logic [19:0]      i_pfn;
   logic [2:0]       i_c;
   logic             i_d;
   logic             i_v;

   logic             d_req;
   logic [18:0]      d_vpn;
   logic             d_odd;
   logic [7:0]       d_asid;
   logic             d_gnt;
   logic             d_rvalid;
   logic             d_found;
   logic [IDX_W-1:0] d_index;
   logic [19:0]      d_pfn;
   logic [2:0]       d_c;
   logic             d_d;
   logic             d_v;

   logic [18:0]      s_vpn;
   logic             s_odd;
   logic [7:0]       s_asid;
   logic             s_found;
   logic [IDX_W-1:0] s_index;
   logic [19:0]      s_pfn;
   logic [2:0]       s_c;
   logic             s_d;
   logic             s_v;

   logic             tlb_we;
   logic             flush;

   modport slave (
      input  i_req, i_vpn, i_odd, i_asid,
      output i_gnt, i_rvalid, i_found, i_index, i_pfn, i_c, i_d, i_v,
      input  d_req, d_vpn, d_odd, d_asid,
      output d_gnt, d_rvalid, d_found, d_index, d_pfn, d_c, d_d, d_v,
      output s_vpn, s_odd, s_asid,
      input  s_found, s_index, s_pfn, s_c, s_d, s_v,
      input  tlb_we, flush
   );

   modport master (
      output i_req, i_vpn, i_odd, i_asid,
      input  i_gnt, i_rvalid, i_found, i_index, i_pfn, i_c, i_d, i_v,
      output d_req, d_vpn, d_odd, d_asid,
      input  d_gnt, d_rvalid, d_found, d_index, d_pfn, d_c, d_d, d_v,
      input  s_vpn, s_odd, s_asid,
      output s_found, s_index, s_pfn, s_c, s_d, s_v,
      output tlb_we, flush
   );
endinterface
`default_nettype wire

// File: rtl/tlb_search_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tlb_search_arbiter : shares one TLB search port between I-fetch and LSU, |
// | two-stage lookup, grant lockout around TLB writes.                      |
// | Optional macro TLB_ARB_RR_EN : round-robin instead of D priority.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tlb_search_arbiter #(
   parameter int TLBNUM     = 16,
   parameter int STARVE_MAX = 3
) (
   input wire                  clk,
   input wire                  resetn,
   tlb_search_arbiter_if.slave bus
);
   localparam int IDX_W = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_WLOCK = 1'b1;
   localparam logic [0:0] OWN_D    = 1'b0;
   localparam logic [0:0] OWN_I    = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             grant_ok, s1_adv;
   logic             i_pick, i_win, d_win;

   logic             s1_valid_q, s1_valid_d;
   logic [0:0]       s1_owner_q, s1_owner_d;
   logic [18:0]      s1_vpn_q, s1_vpn_d;
   logic             s1_odd_q, s1_odd_d;
   logic [7:0]       s1_asid_q, s1_asid_d;

   logic             i_rvalid_q, i_rvalid_d, i_found_q, i_found_d;
   logic [IDX_W-1:0] i_index_q, i_index_d;
   logic [19:0]      i_pfn_q, i_pfn_d;
   logic [2:0]       i_c_q, i_c_d;
   logic             i_d_q, i_d_d, i_v_q, i_v_d;

   logic             d_rvalid_q, d_rvalid_d, d_found_q, d_found_d;
   logic [IDX_W-1:0] d_index_q, d_index_d;
   logic [19:0]      d_pfn_q, d_pfn_d;
   logic [2:0]       d_c_q, d_c_d;
   logic             d_d_q, d_d_d, d_v_q, d_v_d;

   // ---------------- write-lock FSM ----------------
   always_ff @(posedge clk or negedge resetn) begin : p_fsm_reg
      if (!resetn) state_q <= ST_RUN;
      else         state_q <= state_d;
   end

   always_comb begin : p_fsm_next
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (bus.tlb_we) state_d = ST_WLOCK;
         ST_WLOCK: state_d = bus.tlb_we ? ST_WLOCK : ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // The held stage-1 lookup is re-searched only once the write has landed.
   always_comb begin : p_fsm_out
      grant_ok = resetn && (state_q == ST_RUN) && !bus.flush && !bus.tlb_we;
      s1_adv   = s1_valid_q && (state_q == ST_RUN) && !bus.tlb_we;
   end

   // ---------------- arbitration policy ----------------
`ifdef TLB_ARB_RR_EN
   logic last_i_q, last_i_d;

   always_comb begin : p_arb_pick
      i_pick = (bus.i_req && bus.d_req) ? !last_i_q : bus.i_req;
   end

   always_comb begin : p_arb_upd
      last_i_d = last_i_q;
      if (i_win)      last_i_d = 1'b1;
      else if (d_win) last_i_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin : p_arb_reg
      if (!resetn) last_i_q <= 1'b0;
      else         last_i_q <= last_i_d;
   end
`else
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_q, starve_d;

   always_comb begin : p_arb_pick
      i_pick = bus.i_req && (!bus.d_req || (starve_q == C_STARVE_MAX));
   end

   always_comb begin : p_arb_upd
      starve_d = starve_q;
      if (!bus.flush) begin
         if (!bus.i_req || i_win)                     starve_d = '0;
         else if (d_win && (starve_q != C_STARVE_MAX)) starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin : p_arb_reg
      if (!resetn) starve_q <= '0;
      else         starve_q <= starve_d;
   end
`endif

   assign i_win = grant_ok && i_pick;
   assign d_win = grant_ok && bus.d_req && !i_pick;

   // ---------------- lookup pipeline ----------------
   always_comb begin : p_pipe
      s1_valid_d = s1_valid_q && !s1_adv;
      s1_owner_d = s1_owner_q;
      s1_vpn_d   = s1_vpn_q;
      s1_odd_d   = s1_odd_q;
      s1_asid_d  = s1_asid_q;
      if (i_win) begin
         s1_valid_d = 1'b1;
         s1_owner_d = OWN_I;
         s1_vpn_d   = bus.i_vpn;
         s1_odd_d   = bus.i_odd;
         s1_asid_d  = bus.i_asid;
      end else if (d_win) begin
         s1_valid_d = 1'b1;
         s1_owner_d = OWN_D;
         s1_vpn_d   = bus.d_vpn;
         s1_odd_d   = bus.d_odd;
         s1_asid_d  = bus.d_asid;
      end
      if (bus.flush) s1_valid_d = 1'b0;

      i_rvalid_d = 1'b0;
      i_found_d  = i_found_q;
      i_index_d  = i_index_q;
      i_pfn_d    = i_pfn_q;
      i_c_d      = i_c_q;
      i_d_d      = i_d_q;
      i_v_d      = i_v_q;
      d_rvalid_d = 1'b0;
      d_found_d  = d_found_q;
      d_index_d  = d_index_q;
      d_pfn_d    = d_pfn_q;
      d_c_d      = d_c_q;
      d_d_d      = d_d_q;
      d_v_d      = d_v_q;
      // Only the owner's result registers move; the other port keeps its last result.
      if (s1_adv && !bus.flush) begin
         if (s1_owner_q == OWN_I) begin
            i_rvalid_d = 1'b1;
            i_found_d  = bus.s_found;
            i_index_d  = bus.s_index;
            i_pfn_d    = bus.s_pfn;
            i_c_d      = bus.s_c;
            i_d_d      = bus.s_d;
            i_v_d      = bus.s_v;
         end else begin
            d_rvalid_d = 1'b1;
            d_found_d  = bus.s_found;
            d_index_d  = bus.s_index;
            d_pfn_d    = bus.s_pfn;
            d_c_d      = bus.s_c;
            d_d_d      = bus.s_d;
            d_v_d      = bus.s_v;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin : p_pipe_reg
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s1_owner_q <= OWN_D;
         s1_vpn_q   <= '0;
         s1_odd_q   <= 1'b0;
         s1_asid_q  <= '0;
         i_rvalid_q <= 1'b0;
         i_found_q  <= 1'b0;
         i_index_q  <= '0;
         i_pfn_q    <= '0;
         i_c_q      <= '0;
         i_d_q      <= 1'b0;
         i_v_q      <= 1'b0;
         d_rvalid_q <= 1'b0;
         d_found_q  <= 1'b0;
         d_index_q  <= '0;
         d_pfn_q    <= '0;
         d_c_q      <= '0;
         d_d_q      <= 1'b0;
         d_v_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_owner_q <= s1_owner_d;
         s1_vpn_q   <= s1_vpn_d;
         s1_odd_q   <= s1_odd_d;
         s1_asid_q  <= s1_asid_d;
         i_rvalid_q <= i_rvalid_d;
         i_found_q  <= i_found_d;
         i_index_q  <= i_index_d;
         i_pfn_q    <= i_pfn_d;
         i_c_q      <= i_c_d;
         i_d_q      <= i_d_d;
         i_v_q      <= i_v_d;
         d_rvalid_q <= d_rvalid_d;
         d_found_q  <= d_found_d;
         d_index_q  <= d_index_d;
         d_pfn_q    <= d_pfn_d;
         d_c_q      <= d_c_d;
         d_d_q      <= d_d_d;
         d_v_q      <= d_v_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus.i_gnt    = i_win;
   assign bus.d_gnt    = d_win;
   assign bus.i_rvalid = i_rvalid_q && !bus.flush;
   assign bus.d_rvalid = d_rvalid_q && !bus.flush;
   assign bus.i_found  = i_found_q;
   assign bus.i_index  = i_index_q;
   assign bus.i_pfn    = i_pfn_q;
   assign bus.i_c      = i_c_q;
   assign bus.i_d      = i_d_q;
   assign bus.i_v      = i_v_q;
   assign bus.d_found  = d_found_q;
   assign bus.d_index  = d_index_q;
   assign bus.d_pfn    = d_pfn_q;
   assign bus.d_c      = d_c_q;
   assign bus.d_d      = d_d_q;
   assign bus.d_v      = d_v_q;
   assign bus.s_vpn    = s1_vpn_q;
   assign bus.s_odd    = s1_odd_q;
   assign bus.s_asid   = s1_asid_q;
endmodule
`default_nettype wire

// File: tb/tb_tlb_search_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tlb_search_arbiter : directed + random bench with a lookup-level      |
// | reference model of the shared TLB search port.                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tlb_search_arbiter;
   localparam int TLBNUM     = 16;
   localparam int STARVE_MAX = 3;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_e_t;

   typedef struct packed {
      logic        found;
      logic [3:0]  index;
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } res_t;

   logic   clk     = 1'b0;
   logic   resetn  = 1'b0;
   logic   tb_init = 1'b1;
   int     total   = 0;
   int     bad     = 0;
   tlb_e_t tlb [TLBNUM];
   logic [3:0] wr_idx = '0;
   tlb_e_t     wr_ent = '0;

   tlb_search_arbiter_if #(.TLBNUM(TLBNUM)) bus ();

   tlb_search_arbiter #(.TLBNUM(TLBNUM), .STARVE_MAX(STARVE_MAX)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic tlb_e_t init_entry(input int k);
      tlb_e_t e;
      e      = '0;
      e.vpn2 = 19'h003FB + 19'(k);
      e.asid = 8'(k);
      e.g    = 1'b1;
      e.pfn0 = (k == 5) ? 20'h01234 : 20'h01000 + 20'(k * 16);
      e.c0   = 3'(k % 8);
      e.d0   = (k % 2) == 1;
      e.v0   = 1'b1;
      e.pfn1 = 20'h02000 + 20'(k);
      e.c1   = 3'd3;
      e.d1   = 1'b1;
      e.v1   = (k % 3) != 0;
      return e;
   endfunction

   always @(posedge clk) begin
      if (tb_init) begin
         for (int k = 0; k < TLBNUM; k++) tlb[k] <= init_entry(k);
      end else if (bus.tlb_we) begin
         tlb[wr_idx] <= wr_ent;
      end
   end

   // Lowest-numbered matching entry wins.
   function automatic res_t lookup(input logic [18:0] vpn, input logic odd, input logic [7:0] asid);
      res_t r;
      r = '0;
      for (int k = TLBNUM - 1; k >= 0; k--) begin
         if (tlb[k].vpn2 == vpn && (tlb[k].g || tlb[k].asid == asid)) begin
            r.found = 1'b1;
            r.index = 4'(k);
            r.pfn   = odd ? tlb[k].pfn1 : tlb[k].pfn0;
            r.c     = odd ? tlb[k].c1   : tlb[k].c0;
            r.d     = odd ? tlb[k].d1   : tlb[k].d0;
            r.v     = odd ? tlb[k].v1   : tlb[k].v0;
         end
      end
      return r;
   endfunction

   task automatic tlb_resp();
      res_t r;
      r = lookup(bus.s_vpn, bus.s_odd, bus.s_asid);
      bus.s_found = r.found;
      bus.s_index = r.index;
      bus.s_pfn   = r.pfn;
      bus.s_c     = r.c;
      bus.s_d     = r.d;
      bus.s_v     = r.v;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ir, input logic [18:0] iv, input logic dr,
                        input logic [18:0] dv, input logic we, input logic fl);
      bus.i_req  = ir;
      bus.i_vpn  = iv;
      bus.i_odd  = 1'b0;
      bus.i_asid = 8'd0;
      bus.d_req  = dr;
      bus.d_vpn  = dv;
      bus.d_odd  = 1'b0;
      bus.d_asid = 8'd0;
      bus.tlb_we = we;
      bus.flush  = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      tlb_resp();
   endtask

   // ---------------- reference model (lookup level) ----------------
   logic        m_pv, m_pown;      // granted lookup waiting to be searched
   logic [18:0] m_pvpn;
   logic        m_podd;
   logic [7:0]  m_pasid;
   logic        m_dv, m_down;      // result due this cycle and its owner
   res_t        m_res_i, m_res_d;  // last registered result per port
   logic [27:0] m_skey;            // last key presented to the TLB
   logic        m_lock;            // a TLB write happened last cycle
   logic        pick_i, blocked, gi, gd;
   res_t        m_r;
`ifdef TLB_ARB_RR_EN
   logic        m_last_i;
`else
   int          m_streak;
`endif

   always @(negedge clk) begin : p_compare
      if (!resetn) begin
         m_pv = 0; m_pown = 0; m_pvpn = '0; m_podd = 0; m_pasid = '0;
         m_dv = 0; m_down = 0; m_res_i = '0; m_res_d = '0; m_skey = '0; m_lock = 0;
`ifdef TLB_ARB_RR_EN
         m_last_i = 1'b0;
`else
         m_streak = 0;
`endif
      end else begin
         chk("i_rvalid", bus.i_rvalid, m_dv && m_down && !bus.flush);
         chk("d_rvalid", bus.d_rvalid, m_dv && !m_down && !bus.flush);
         chk("i_result", {bus.i_found, bus.i_index, bus.i_pfn, bus.i_c, bus.i_d, bus.i_v}, m_res_i);
         chk("d_result", {bus.d_found, bus.d_index, bus.d_pfn, bus.d_c, bus.d_d, bus.d_v}, m_res_d);
         chk("s_key", {bus.s_vpn, bus.s_odd, bus.s_asid}, m_skey);

         blocked = m_lock || bus.tlb_we || bus.flush;
`ifdef TLB_ARB_RR_EN
         pick_i = (bus.i_req && bus.d_req) ? !m_last_i : bus.i_req;
`else
         pick_i = bus.i_req && (!bus.d_req || m_streak >= STARVE_MAX);
`endif
         gi = !blocked && pick_i;
         gd = !blocked && bus.d_req && !pick_i;
         chk("i_gnt", bus.i_gnt, gi);
         chk("d_gnt", bus.d_gnt, gd);

         m_dv = 1'b0;
         if (m_pv && !m_lock && !bus.tlb_we) begin
            if (!bus.flush) begin
               m_r = lookup(m_pvpn, m_podd, m_pasid);
               if (m_pown) m_res_i = m_r;
               else        m_res_d = m_r;
               m_dv   = 1'b1;
               m_down = m_pown;
            end
            m_pv = 1'b0;
         end
         if (bus.flush) m_pv = 1'b0;
         if (gi || gd) begin
            m_pv    = 1'b1;
            m_pown  = gi;
            m_pvpn  = gi ? bus.i_vpn  : bus.d_vpn;
            m_podd  = gi ? bus.i_odd  : bus.d_odd;
            m_pasid = gi ? bus.i_asid : bus.d_asid;
            m_skey  = {m_pvpn, m_podd, m_pasid};
         end
         m_lock = bus.tlb_we;
`ifdef TLB_ARB_RR_EN
         if (gi)      m_last_i = 1'b1;
         else if (gd) m_last_i = 1'b0;
`else
         if (!bus.flush) begin
            if (!bus.i_req || gi) m_streak = 0;
            else if (gd)          m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
         end
`endif
      end
   end

   // ---------------- stimulus with literal expectations ----------------
   initial begin
      drive(0, '0, 0, '0, 0, 0);
      tlb_resp();
      @(posedge clk);
      #1;
      tb_init = 1'b0;
      @(negedge clk);
      chk("rst_i_rvalid", bus.i_rvalid, 0);
      chk("rst_d_found", bus.d_found, 0);
      chk("rst_i_pfn", bus.i_pfn, 0);
      step();
      resetn = 1'b1;

      // single I lookup hitting entry 5
      step(); drive(1, 19'h00400, 0, '0, 0, 0);
      @(negedge clk); chk("t1_i_gnt", bus.i_gnt, 1);
      step(); drive(0, '0, 0, '0, 0, 0);
      step();
      @(negedge clk);
      chk("t1_i_rvalid", bus.i_rvalid, 1);
      chk("t1_i_found", bus.i_found, 1);
      chk("t1_i_index", bus.i_index, 5);
      chk("t1_i_pfn", bus.i_pfn, 20'h01234);

      // both requesting continuously
      for (int k = 0; k < 12; k++) begin
         step(); drive(1, 19'h003FC, 1, 19'h003FD, 0, 0);
         @(negedge clk);
`ifdef TLB_ARB_RR_EN
         chk("t2_d_gnt", bus.d_gnt, (k % 2) == 0);
`else
         chk("t2_d_gnt", bus.d_gnt, (k % 4) != 3);
`endif
      end
      repeat (3) begin step(); drive(0, '0, 0, '0, 0, 0); end

      // back-to-back D lookups, entries 0..5
      for (int j = 0; j < 8; j++) begin
         step();
         if (j < 6) drive(0, '0, 1, 19'h003FB + 19'(j), 0, 0);
         else       drive(0, '0, 0, '0, 0, 0);
         @(negedge clk);
         if (j >= 2) begin
            chk("t3_d_rvalid", bus.d_rvalid, 1);
            chk("t3_d_index", bus.d_index, 4'(j - 2));
         end
      end

      // TLB write right after a D grant rewrites the hit entry
      step(); drive(0, '0, 1, 19'h00400, 0, 0);
      @(negedge clk); chk("t4_d_gnt", bus.d_gnt, 1);
      step(); drive(1, 19'h003FB, 0, '0, 1, 0);
      wr_idx = 4'd5; wr_ent = init_entry(5); wr_ent.pfn0 = 20'h0ABCD;
      @(negedge clk); chk("t4_i_gnt_we", bus.i_gnt, 0);
      step(); drive(1, 19'h003FB, 0, '0, 0, 0);
      @(negedge clk); chk("t4_i_gnt_lock", bus.i_gnt, 0); chk("t4_d_rv_lock", bus.d_rvalid, 0);
      step();
      @(negedge clk); chk("t4_i_gnt_run", bus.i_gnt, 1); chk("t4_d_rv_run", bus.d_rvalid, 0);
      step(); drive(0, '0, 0, '0, 0, 0);
      @(negedge clk); chk("t4_d_rvalid", bus.d_rvalid, 1); chk("t4_d_pfn", bus.d_pfn, 20'h0ABCD);
      step();
      @(negedge clk); chk("t4_i_rvalid", bus.i_rvalid, 1);

      // flush with two lookups in flight
      step(); drive(0, '0, 1, 19'h003FB, 0, 0);
      step(); drive(0, '0, 1, 19'h003FC, 0, 0);
      step(); drive(0, '0, 1, 19'h003FC, 0, 1);
      @(negedge clk); chk("t5_gnt_flush", bus.d_gnt, 0); chk("t5_rv_flush", bus.d_rvalid, 0);
      step(); drive(0, '0, 1, 19'h003FD, 0, 0);
      @(negedge clk); chk("t5_gnt_next", bus.d_gnt, 1); chk("t5_rv_after", bus.d_rvalid, 0);
      step(); drive(0, '0, 0, '0, 0, 0);
      @(negedge clk); chk("t5_rv_gap", bus.d_rvalid, 0);
      step();
      @(negedge clk); chk("t5_rv_next", bus.d_rvalid, 1); chk("t5_index", bus.d_index, 2);

      // asynchronous reset in the middle of a lookup
      step(); drive(1, 19'h003FE, 0, '0, 0, 0);
      @(negedge clk); chk("t6_gnt", bus.i_gnt, 1);
      step();
      #1 resetn = 1'b0;
      #1;
      chk("t6_i_gnt", bus.i_gnt, 0);
      chk("t6_i_rvalid", bus.i_rvalid, 0);
      chk("t6_i_pfn", bus.i_pfn, 0);
      chk("t6_d_pfn", bus.d_pfn, 0);
      chk("t6_s_vpn", bus.s_vpn, 0);
      step(); drive(0, '0, 0, '0, 0, 0);
      resetn = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); chk("t6_no_rv", bus.i_rvalid | bus.d_rvalid, 0);
         step();
      end

      // randomized traffic, writes and flushes
      for (int n = 0; n < 2500; n++) begin
         step();
         bus.i_req  = ($urandom % 100) < 60;
         bus.i_vpn  = 19'h003F8 + 19'($urandom_range(0, 23));
         bus.i_odd  = 1'($urandom % 2);
         bus.i_asid = 8'($urandom_range(0, 3));
         bus.d_req  = ($urandom % 100) < 60;
         bus.d_vpn  = 19'h003F8 + 19'($urandom_range(0, 23));
         bus.d_odd  = 1'($urandom % 2);
         bus.d_asid = 8'($urandom_range(0, 3));
         bus.tlb_we = ($urandom % 100) < 6;
         bus.flush  = ($urandom % 100) < 4;
         wr_idx     = 4'($urandom % 16);
         wr_ent     = '0;
         wr_ent.vpn2 = 19'h003F8 + 19'($urandom_range(0, 23));
         wr_ent.asid = 8'($urandom_range(0, 3));
         wr_ent.g    = 1'($urandom % 2);
         wr_ent.pfn0 = 20'($urandom);
         wr_ent.c0   = 3'($urandom);
         wr_ent.d0   = 1'($urandom % 2);
         wr_ent.v0   = 1'($urandom % 2);
         wr_ent.pfn1 = 20'($urandom);
         wr_ent.c1   = 3'($urandom);
         wr_ent.d1   = 1'($urandom % 2);
         wr_ent.v1   = 1'($urandom % 2);
      end
      step(); drive(0, '0, 0, '0, 0, 0);
      repeat (4) step();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tlb_search_arbiter.md
Name: tlb_search_arbiter

Overview:
- Shares one TLB search port between the instruction-fetch requester (port I) and the LSU requester (port D).
- Pipelines each lookup over two cycles: grant/capture, then search/register.
- Blocks grants around TLB writes (TLBWI/TLBWR) so no requester sees a stale translation.
- Sits between mmu_inst/mmu_data and the tlb block, and occupies the tlb search port 2 slot.

Parameters:
- TLBNUM, 16, TLB entry count; index width is $clog2(TLBNUM).
- STARVE_MAX, 3, maximum consecutive D grants while I is requesting before I is forced.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  I lookup request
- i_vpn  in  19  I VPN2
- i_odd  in  1  I odd-page select
- i_asid  in  8  I ASID
- i_gnt  out  1  I request accepted this cycle (combinational)
- i_rvalid  out  1  I result valid (1-cycle pulse)
- i_found / i_index / i_pfn / i_c / i_d / i_v  out  1/clog2/20/3/1/1  I registered result
- d_req, d_vpn, d_odd, d_asid, d_gnt, d_rvalid, d_found, d_index, d_pfn, d_c, d_d, d_v  same widths, D port
- s_vpn  out  19  to tlb
- s_odd  out  1  to tlb
- s_asid  out  8  to tlb
- s_found / s_index / s_pfn / s_c / s_d / s_v  in  from tlb (combinational)
- tlb_we  in  1  TLB write strobe this cycle
- flush  in  1  pipeline flush; discard in-flight lookups

Behaviour:
- Reset (resetn low, asynchronous):
  - all *_gnt, *_rvalid, *_found low; all result fields 0
  - stage registers invalid; starve counter 0; state RUN.
- Stage 0 (grant), evaluated in cycle N when state RUN, flush low, tlb_we low:
  - Default arbitration: D has priority.
  - I wins if D is not requesting, or if starve_cnt == STARVE_MAX.
  - At most one grant per cycle.
  - Winner's vpn/odd/asid/owner are captured into stage-1 registers at the edge.
- Stage 1 (search), cycle N+1:
  - s_vpn/s_odd/s_asid are driven from the stage-1 registers; when stage 1 is invalid they are held at their last value.
  - s_* results plus owner are captured into stage-2 registers.
- Stage 2 (result), cycle N+2:
  - The owner's *_rvalid pulses high for one cycle with registered results.
  - The non-owner's rvalid stays low; its result fields hold their previous values.
- Throughput: one lookup per cycle. Latency: gnt to rvalid = 2 cycles.
- Starve counter:
  - increments on a D grant while i_req is high;
  - clears on an I grant, or when i_req is low;
  - saturates at STARVE_MAX.
- States RUN and WLOCK:
  - RUN -> WLOCK on tlb_we.
  - WLOCK -> RUN after exactly 1 cycle.
  - No grants when tlb_we is high or state is WLOCK.
- Write hazard:
  - If tlb_we is high while stage 1 is valid, the stage-1 lookup is not advanced to stage 2.
  - Its request is held and re-searched in the first RUN cycle; its rvalid is delayed accordingly.
  - The requester must not re-request; the original grant still stands.
  - A lookup already in stage 2 completes normally.
- Flush:
  - Clears stage-1 and stage-2 valid, including held replays; suppresses that cycle's rvalid.
  - Grants no request in the flush cycle; starve counter unchanged.
- flush and tlb_we in the same cycle: flush wins the pipeline clear, and the state still enters WLOCK.
- Requester rule: vpn/odd/asid need only be stable in the cycle gnt is high.

Optional Feature:
- Macro: TLB_ARB_RR_EN.
- Defined: strict round-robin between I and D.
  - A last-winner bit, reset to D, selects the other port when both request.
  - The starve counter and STARVE_MAX are unused.
- Undefined: D priority with starvation guard, as above.

Test Plan:
- Single I lookup:
  - Stimulus: i_req=1, i_vpn=19'h00400, TLB entry 5 maps pfn 20'h01234, v=1.
  - Response: i_gnt in cycle 0; i_rvalid in cycle 2 with found=1, index=5, pfn=20'h01234.
- Both requesters continuously, default build:
  - Response: D granted 3 times, then I once, repeating.
  - With TLB_ARB_RR_EN: D, I, D, I...
- Back-to-back D lookups every cycle:
  - Response: d_rvalid high every cycle from cycle 2 onward, with results in request order.
- tlb_we one cycle after a D grant, rewriting the hit entry with pfn 20'h0ABCD:
  - Response: no grants for 2 cycles; lookup replayed; d_rvalid carries pfn 20'h0ABCD, not the old value.
- Flush with two lookups in flight:
  - Response: no rvalid for either; the next grant returns a normal result 2 cycles later.
- resetn asserted mid-lookup:
  - Response: all outputs 0 immediately (asynchronously); no rvalid after release until a new grant.
